pipe_stage_reg: RTL

Parametrised pipeline-stage register with valid/ready handshake, stall, flush-to-bubble and a saturating stall counter. It is the generic successor to the fixed ID/EX latch and is instantiated between every pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS32 pipeline. Datapath and control fields are carried separately so that a flush or bubble zeroes the control field; RegWrite and MemWrite can therefore never leak from a squashed instruction.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 93 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and control-field layout for the MIPS32 inter-stage registers.
package pipe_pkg;

    // ID/EX: PC+4, rs data, rt data, sign-extended imm (4x32) plus rt, rd (2x5)
    localparam int IDEX_DATA_W = 138;
    localparam int IDEX_CTRL_W = 10;

    localparam int CTRL_MEMTOREG  = 0;
    localparam int CTRL_REGWRITE  = 1;
    localparam int CTRL_ALUSRC    = 2;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_ALUOP_LSB = 4;
    localparam int CTRL_ALUOP_MSB = 6;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_BRANCH    = 8;
    localparam int CTRL_REGDST    = 9;

    // IF/ID carries no decoded control; one bit keeps the port width legal
    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 1;
    localparam int EXMEM_DATA_W = 102;
    localparam int EXMEM_CTRL_W = 5;
    localparam int MEMWB_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 2;

    typedef struct packed {
        logic       regDst;
        logic       branch;
        logic       memRead;
        logic [2:0] aluOp;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic       memToReg;
    } idex_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, data, ctrl} storage slot; clear beats load so a squash always wins.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadEn,
    input  logic              clearEn,
    input  logic [DATA_W-1:0] inData,
    input  logic [CTRL_W-1:0] inCtrl,
    output logic              slotValid,
    output logic [DATA_W-1:0] slotData,
    output logic [CTRL_W-1:0] slotCtrl
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slotValid <= 1'b0;
            slotData  <= '0;
            slotCtrl  <= '0;
        end else if (clearEn) begin
            // data is left stale; only ctrl must be zero to stop side effects
            slotValid <= 1'b0;
            slotCtrl  <= '0;
        end else if (loadEn) begin
            slotValid <= 1'b1;
            slotData  <= inData;
            slotCtrl  <= inCtrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready, flush-to-bubble and saturating stall counter.
// Define PIPE_SKID_EN to add a skid slot and cut the out_ready-to-in_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              mainValid, mainLoad, mainClear;
    logic [DATA_W-1:0] mainData, mainDataIn;
    logic [CTRL_W-1:0] mainCtrl, mainCtrlIn;
    logic              inFire, outFire;
    logic [CNT_W-1:0]  stallCnt;

    assign inFire  = in_valid & in_ready;
    assign outFire = mainValid & out_ready;

`ifdef PIPE_SKID_EN
    logic              skidValid, skidLoad, skidClear;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    // skid full means no room, and the skid never refills in the cycle it drains
    assign in_ready   = ~skidValid;
    assign skidLoad   = inFire & mainValid & ~out_ready;
    assign skidClear  = flush | (outFire & skidValid);
    assign mainLoad   = (outFire & skidValid) | (inFire & (~mainValid | out_ready));
    assign mainClear  = flush | (outFire & ~skidValid & ~inFire);
    assign mainDataIn = skidValid ? skidData : in_data;
    assign mainCtrlIn = skidValid ? skidCtrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skidSlot (
        .clk      (clk),
        .rst      (rst),
        .loadEn   (skidLoad),
        .clearEn  (skidClear),
        .inData   (in_data),
        .inCtrl   (in_ctrl),
        .slotValid(skidValid),
        .slotData (skidData),
        .slotCtrl (skidCtrl)
    );
`else
    assign in_ready   = out_ready | ~mainValid;
    assign mainLoad   = inFire;
    assign mainClear  = flush | (outFire & ~inFire);
    assign mainDataIn = in_data;
    assign mainCtrlIn = in_ctrl;
`endif

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) mainSlot (
        .clk      (clk),
        .rst      (rst),
        .loadEn   (mainLoad),
        .clearEn  (mainClear),
        .inData   (mainDataIn),
        .inCtrl   (mainCtrlIn),
        .slotValid(mainValid),
        .slotData (mainData),
        .slotCtrl (mainCtrl)
    );

    // flush deliberately leaves the counter alone
    always_ff @(posedge clk) begin
        if (rst)
            stallCnt <= '0;
        else if (mainValid && !out_ready && stallCnt != CNT_MAX)
            stallCnt <= stallCnt + 1'b1;
    end

    assign out_valid = mainValid;
    assign out_data  = mainData;
    assign out_ctrl  = mainCtrl;
    assign stall_cnt = stallCnt;

endmodule
